// File: rtl/clock_time_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module      : clock_time_ctrl_if
// Description : Button, display-refresh handshake and time outputs of the
//               LCD clock timekeeping controller.
// Revision    : 1.0 - initial release
// =============================================================================
interface clock_time_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       upd_ack;
    logic       upd_req;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;
    logic       tick;

    // master: the controller; slave: buttons plus LCD writer
    modport master (
        input  btn_mode, btn_inc, upd_ack,
        output upd_req, hours, minutes, seconds, mode, blink, tick
    );
    modport slave (
        output btn_mode, btn_inc, upd_ack,
        input  upd_req, hours, minutes, seconds, mode, blink, tick
    );
endinterface
`default_nettype wire

// File: rtl/clock_time_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : clock_time_ctrl
// Description : HH:MM:SS timekeeping with 1 Hz enable, RUN/SET mode FSM,
//               field blink and LCD refresh req/ack. Macro SET_SEC_EN adds
//               the SET_S (seconds setting) state.
// Revision    : 1.0 - initial release
// =============================================================================
module clock_time_ctrl #(
    parameter int CLK_HZ  = 50000000,
    parameter int HALF_HZ = CLK_HZ / 2
) (
    input wire                 clk,
    input wire                 rst,
    clock_time_ctrl_if.master  bus
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int BW = (HALF_HZ > 1) ? $clog2(HALF_HZ) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [PW-1:0]  r_pres;
    logic [BW-1:0]  r_bcnt;
    logic [4:0]     r_hours;
    logic [5:0]     r_minutes;
    logic [5:0]     r_seconds;
    logic           r_blink;
    logic           r_tick;
    logic           r_req;

    logic           w_run;
    logic           w_inc_ok;
    logic           w_tick_next;
    logic           w_blink_tog;
    logic           w_event;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.btn_mode) begin
            case (r_state)
                ST_RUN:   w_next = ST_SET_H;
                ST_SET_H: w_next = ST_SET_M;
`ifdef SET_SEC_EN
                ST_SET_M: w_next = ST_SET_S;
`else
                ST_SET_M: w_next = ST_RUN;
`endif
                default:  w_next = ST_RUN;
            endcase
        end
    end

    // A mode press always changes state, so it masks any same-cycle inc.
    always_comb begin
        w_run       = (r_state == ST_RUN);
        w_inc_ok    = bus.btn_inc && !bus.btn_mode && !w_run;
        w_tick_next = w_run && !bus.btn_mode && (r_pres == PW'(CLK_HZ - 1));
        w_blink_tog = !w_run && !bus.btn_mode && (r_bcnt == BW'(HALF_HZ - 1));
        w_event     = r_tick || w_inc_ok || bus.btn_mode || w_blink_tog;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pres <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick_next;
            if (!w_run || bus.btn_mode || (r_pres == PW'(CLK_HZ - 1)))
                r_pres <= '0;
            else
                r_pres <= r_pres + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
        end else if (bus.btn_mode) begin
            r_bcnt  <= '0;
            r_blink <= (w_next != ST_RUN);
        end else if (w_run) begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
        end else if (w_blink_tog) begin
            r_bcnt  <= '0;
            r_blink <= ~r_blink;
        end else begin
            r_bcnt  <= r_bcnt + 1'b1;
        end
    end

    // r_tick can only be high in RUN, so it never collides with set-mode edits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hours   <= 5'd0;
            r_minutes <= 6'd0;
            r_seconds <= 6'd0;
        end else if (r_tick) begin
            if (r_seconds == 6'd59) begin
                r_seconds <= 6'd0;
                if (r_minutes == 6'd59) begin
                    r_minutes <= 6'd0;
                    r_hours   <= (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
                end else begin
                    r_minutes <= r_minutes + 6'd1;
                end
            end else begin
                r_seconds <= r_seconds + 6'd1;
            end
        end else if (w_inc_ok) begin
            case (r_state)
                ST_SET_H: r_hours   <= (r_hours   == 5'd23) ? 5'd0 : r_hours   + 5'd1;
                ST_SET_M: r_minutes <= (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
`ifdef SET_SEC_EN
                ST_SET_S: r_seconds <= (r_seconds == 6'd59) ? 6'd0 : r_seconds + 6'd1;
`endif
                default: ;
            endcase
        end
`ifndef SET_SEC_EN
        else if (bus.btn_mode && (r_state == ST_SET_M)) begin
            r_seconds <= 6'd0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_req <= 1'b1;
        else     r_req <= w_event || (r_req && !bus.upd_ack);
    end

    assign bus.upd_req = r_req;
    assign bus.hours   = r_hours;
    assign bus.minutes = r_minutes;
    assign bus.seconds = r_seconds;
    assign bus.mode    = r_state;
    assign bus.blink   = r_blink;
    assign bus.tick    = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_clock_time_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tb_clock_time_ctrl
// Description : Self-checking bench for clock_time_ctrl (CLK_HZ=10, HALF_HZ=5).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_clock_time_ctrl;

    localparam int CLK  = 10;
    localparam int HALF = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   rnd_en = 1'b0;

    clock_time_ctrl_if bus ();

    clock_time_ctrl #(.CLK_HZ(CLK), .HALF_HZ(HALF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Reference model: absolute time in seconds plus cycles since last mode change
    int m_time;
    int m_mode;
    int m_el;
    bit m_req;

    function automatic bit m_tick();
        return (m_mode == 0) && (m_el > 0) && (m_el % CLK == 0);
    endfunction

    function automatic bit m_blink();
        return (m_mode != 0) && ((m_el / HALF) % 2 == 0);
    endfunction

    function automatic int f_mode(int md, bit bm);
        if (!bm) return md;
        if (md == 0) return 1;
        if (md == 1) return 2;
`ifdef SET_SEC_EN
        if (md == 2) return 3;
`endif
        return 0;
    endfunction

    function automatic int f_time(int t, int md, bit tk, bit bm, bit bi);
        int h;
        int mi;
        int s;
        h  = t / 3600;
        mi = (t / 60) % 60;
        s  = t % 60;
        if (tk) return (t + 1) % 86400;
        if (bi && !bm) begin
            if (md == 1)      h  = (h + 1) % 24;
            else if (md == 2) mi = (mi + 1) % 60;
            else if (md == 3) s  = (s + 1) % 60;
        end
`ifndef SET_SEC_EN
        if (bm && md == 2) s = 0;
`endif
        return h * 3600 + mi * 60 + s;
    endfunction

    function automatic bit m_event();
        return m_tick() || bus.btn_mode || (bus.btn_inc && m_mode != 0)
            || (m_mode != 0 && ((m_el + 1) % HALF == 0));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_time <= 0;
            m_mode <= 0;
            m_el   <= 0;
            m_req  <= 1'b1;
        end else begin
            m_time <= f_time(m_time, m_mode, m_tick(), bus.btn_mode, bus.btn_inc);
            m_mode <= f_mode(m_mode, bus.btn_mode);
            m_el   <= bus.btn_mode ? 0 : m_el + 1;
            m_req  <= m_event() || (m_req && !bus.upd_ack);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s, input int md);
        chk({name, " hours"},   int'(bus.hours),   h);
        chk({name, " minutes"}, int'(bus.minutes), m);
        chk({name, " seconds"}, int'(bus.seconds), s);
        chk({name, " mode"},    int'(bus.mode),    md);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive for one sampling edge; returns on the negedge after it
    task automatic pulse(input bit bm, input bit bi);
        bus.btn_mode = bm;
        bus.btn_inc  = bi;
        @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
    endtask

    task automatic press(input bit bm, input bit bi, input int n);
        for (int i = 0; i < n; i++) begin
            pulse(bm, bi);
            @(negedge clk);
        end
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tick && n < 40);
        chk({name, " tick seen"}, int'(bus.tick), 1);
    endtask

    typedef struct {
        bit bm;
        bit bi;
        int reps;
        int h;
        int m;
        int s;
        int md;
    } vec_t;

`ifdef SET_SEC_EN
    localparam int NV = 10;
`else
    localparam int NV = 9;
`endif
    vec_t vt [NV];

    initial begin
        int n;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.upd_ack  = 1'b0;

        // ---- reset values and 1 Hz sequencing with prompt acks
        do_reset();
        chk_time("reset", 0, 0, 0, 0);
        chk("reset blink", int'(bus.blink),   0);
        chk("reset tick",  int'(bus.tick),    0);
        chk("reset req",   int'(bus.upd_req), 1);
        bus.upd_ack = bus.upd_req;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            chk("t1 tick",    int'(bus.tick),    int'(k % 10 == 0));
            chk("t1 seconds", int'(bus.seconds), (k - 1) / 10);
            chk("t1 req",     int'(bus.upd_req), int'(k > 10 && k % 10 == 1));
            bus.upd_ack = bus.upd_req;
        end

        // ---- blink phase after entering SET_H
        do_reset();
        bus.upd_ack = 1'b1;
        pulse(1'b1, 1'b0);
        for (int j = 0; j < 12; j++) begin
            if (j > 0) @(negedge clk);
            chk("blink phase", int'(bus.blink), int'((j / HALF) % 2 == 0));
            chk("set no tick", int'(bus.tick), 0);
        end

        // ---- table-driven set-mode sequence
        vt[0] = '{1, 0, 1,  0, 0, 0, 1};
        vt[1] = '{0, 1, 25, 1, 0, 0, 1};
        vt[2] = '{1, 1, 1,  1, 0, 0, 2};
        vt[3] = '{0, 1, 59, 1, 59, 0, 2};
        vt[4] = '{0, 1, 2,  1, 1, 0, 2};
`ifdef SET_SEC_EN
        vt[5] = '{1, 0, 1,  1, 1, 0, 3};
        vt[6] = '{0, 1, 3,  1, 1, 3, 3};
        vt[7] = '{1, 0, 1,  1, 1, 3, 0};
        vt[8] = '{1, 0, 1,  1, 1, 3, 1};
        vt[9] = '{0, 1, 23, 0, 1, 3, 1};
`else
        vt[5] = '{1, 0, 1,  1, 1, 0, 0};
        vt[6] = '{0, 1, 3,  1, 1, 0, 0};
        vt[7] = '{1, 0, 1,  1, 1, 0, 1};
        vt[8] = '{0, 1, 23, 0, 1, 0, 1};
`endif
        do_reset();
        for (int v = 0; v < NV; v++) begin
            press(vt[v].bm, vt[v].bi, vt[v].reps);
            chk_time($sformatf("vec%0d", v), vt[v].h, vt[v].m, vt[v].s, vt[v].md);
            chk($sformatf("vec%0d tick", v), int'(bus.tick), 0);
        end

        // ---- 23:59:59 rollover
        do_reset();
        bus.upd_ack = 1'b1;
        press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 23);
        press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 59);
`ifdef SET_SEC_EN
        press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 59);
`endif
        press(1'b1, 1'b0, 1);
        chk("roll preload mode", int'(bus.mode), 0);
        n = 0;
        while (!(bus.tick && bus.seconds == 6'd59) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("roll wait", int'(bus.tick && bus.seconds == 6'd59), 1);
        chk_time("roll before", 23, 59, 59, 0);
        @(negedge clk);
        chk_time("roll after", 0, 0, 0, 0);
        chk("roll req", int'(bus.upd_req), 1);
        @(negedge clk);
        chk("roll req done", int'(bus.upd_req), 0);

        // ---- ack withheld across ticks, then released, then ack with tick
        bus.upd_ack = 1'b0;
        wait_tick("hold");
        @(negedge clk);
        chk("hold req", int'(bus.upd_req), 1);
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            chk("hold req kept", int'(bus.upd_req), 1);
        end
        wait_tick("ack");
        @(negedge clk);
        bus.upd_ack = 1'b1;
        @(negedge clk);
        bus.upd_ack = 1'b0;
        chk("ack clears req", int'(bus.upd_req), 0);
        wait_tick("pend");
        @(negedge clk);
        chk("pend req", int'(bus.upd_req), 1);
        wait_tick("ack+tick");
        bus.upd_ack = 1'b1;
        @(negedge clk);
        bus.upd_ack = 1'b0;
        chk("ack+tick req", int'(bus.upd_req), 1);
        @(negedge clk);
        chk("ack+tick req kept", int'(bus.upd_req), 1);
        bus.upd_ack = 1'b1;

        // ---- leaving set modes at 10:20:37
        do_reset();
        press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 10);
        press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 20);
`ifdef SET_SEC_EN
        press(1'b1, 1'b0, 1);
`endif
        press(1'b1, 1'b0, 1);
        n = 0;
        while (bus.seconds != 6'd37 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk_time("preset", 10, 20, 37, 0);
        press(1'b1, 1'b0, 2);
`ifdef SET_SEC_EN
        press(1'b1, 1'b0, 1);
        chk("sec mode", int'(bus.mode), 3);
        press(1'b0, 1'b1, 3);
        chk("sec inc", int'(bus.seconds), 40);
        pulse(1'b1, 1'b0);
        chk_time("exit", 10, 20, 40, 0);
`else
        pulse(1'b1, 1'b0);
        chk_time("exit", 10, 20, 0, 0);
`endif
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            chk("exit tick", int'(bus.tick), int'(j == 10));
        end

        // ---- asynchronous reset from SET_M with a pending request
        do_reset();
        bus.upd_ack = 1'b0;
        press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 2);
        press(1'b1, 1'b0, 1);
        chk_time("pre-rst", 2, 0, 0, 2);
        #2 rst = 1'b1;
        #1;
        chk_time("async rst", 0, 0, 0, 0);
        chk("async rst blink", int'(bus.blink),   0);
        chk("async rst tick",  int'(bus.tick),    0);
        chk("async rst req",   int'(bus.upd_req), 1);

        // ---- randomized run against the reference model
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            bus.btn_mode = ($urandom_range(0, 29) == 0);
            bus.btn_inc  = ($urandom_range(0, 3) == 0);
            bus.upd_ack  = ($urandom_range(0, 1) == 0);
            @(negedge clk);
            chk("rnd hours",   int'(bus.hours),   m_time / 3600);
            chk("rnd minutes", int'(bus.minutes), (m_time / 60) % 60);
            chk("rnd seconds", int'(bus.seconds), m_time % 60);
            chk("rnd mode",    int'(bus.mode),    m_mode);
            chk("rnd blink",   int'(bus.blink),   int'(m_blink()));
            chk("rnd tick",    int'(bus.tick),    int'(m_tick()));
            chk("rnd req",     int'(bus.upd_req), int'(m_req));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
Timekeeping controller for the LCD clock. Derives a single-cycle 1 Hz enable from the system clock and sequences the HH:MM:SS counters. Runs a RUN/SET mode FSM driven by pre-debounced button pulses. Requests LCD refreshes through a req/ack handshake toward the LCD writer.

Parameters:
CLK_HZ, 50000000, system clock frequency; prescaler period in cycles (minimum 4, even)
HALF_HZ, CLK_HZ/2, blink half-period in cycles

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous active-high reset
btn_mode  in  1  single-cycle pulse, advance FSM mode (already debounced)
btn_inc  in  1  single-cycle pulse, increment selected field (already debounced)
upd_ack  in  1  LCD writer accepted current values
upd_req  out  1  display refresh request, level, held until ack
hours  out  5  0..23
minutes  out  6  0..59
seconds  out  6  0..59
mode  out  2  0=RUN, 1=SET_H, 2=SET_M, 3=SET_S (only with SET_SEC_EN)
blink  out  1  field-blink phase for LCD writer; 0 in RUN
tick  out  1  1 Hz single-cycle enable (debug/other consumers)

Behaviour:
- Reset, async on rst high: hours=0, minutes=0, seconds=0, mode=RUN, upd_req=1 (forces initial paint), blink=0, tick=0, prescaler=0, blink counter=0.
- Prescaler: counts 0..CLK_HZ-1 and wraps. tick=1 for exactly one cycle when the count equals CLK_HZ-1. Counts in RUN only; held at 0 in any SET state. No derived clocks; tick is an enable.
- RUN: on tick, seconds+1. At 59, seconds wraps to 0 and minutes+1. At minutes 59, minutes wraps and hours+1. At hours 23, hours wraps to 0. 23:59:59 -> 00:00:00 in one cycle.
- FSM transitions on btn_mode: RUN->SET_H->SET_M->RUN. With SET_SEC_EN: RUN->SET_H->SET_M->SET_S->RUN.
- Entering SET_H from RUN: prescaler cleared; time frozen.
- SET_H: btn_inc increments hours, 23->0.
- SET_M: btn_inc increments minutes, 59->0. No carry into hours.
- Exit to RUN: prescaler restarts at 0. First tick occurs CLK_HZ cycles after the exit edge.
- btn_mode and btn_inc in the same cycle: mode change wins; inc ignored.
- btn_inc in RUN: ignored.
- blink: in SET states, toggles every HALF_HZ cycles. On every mode change, the blink counter clears and blink=1. In RUN, blink=0.
- upd_req trigger events: tick in RUN, accepted inc, mode change, or blink toggle.
  - On an event, upd_req goes high the next cycle.
  - Once high, upd_req stays high until upd_ack is sampled high, then deasserts the following cycle.
  - Events while pending coalesce; there is no queue.
  - upd_ack and a new event in the same cycle: upd_req stays 1.
  - upd_ack while upd_req=0: ignored.
- Outputs are registered; counter values update the cycle after the causing event.
- rst mid-operation, including SET modes and pending req: immediate return to reset values.

Optional Feature:
SET_SEC_EN
- Defined: adds the SET_S state. btn_inc increments seconds 59->0 with no carry. Seconds are preserved on exit to RUN.
- Undefined: no SET_S state; mode never equals 3. Exiting SET_M clears seconds to 0 in the same cycle as the transition to RUN.

Test Plan:
All scenarios use CLK_HZ=10, HALF_HZ=5.
1. Release rst, ack every req after 1 cycle. Expect: tick every 10 cycles; seconds 0->1 on the cycle after the first tick; upd_req high once per tick; initial upd_req=1 after reset.
2. Preload 23:59:59 via SET modes, return to RUN. Expect: after 10 cycles, 00:00:00 in a single cycle, with one upd_req.
3. btn_mode to SET_H, 25 btn_inc pulses. Expect: hours=1, tick never asserts, blink toggles every 5 cycles starting at 1. Then btn_mode with btn_inc in the same cycle: mode=SET_M, hours unchanged.
4. Hold upd_ack=0 through 3 ticks. Expect: upd_req stays 1. Pulse ack. Expect: upd_req=0 next cycle. Then ack coincident with a tick: upd_req remains 1.
5. Without SET_SEC_EN: at 10:20:37, btn_mode x3. Expect: 10:20:00 in RUN, next tick 10 cycles later. With SET_SEC_EN: btn_mode x3 reaches SET_S, 3 inc pulses give 40, btn_mode gives RUN at 10:20:40.
6. Assert rst while in SET_M with upd_req pending. Expect: outputs at reset values in the same cycle (async), mode=RUN.
